// File: rtl/trig_pkg.sv
// trig_pkg: shared capture FSM state and trigger-source bit positions
package trig_pkg;
  typedef enum logic [2:0] {IDLE, PRETRIG, ARMED, POSTTRIG, DONE} state_t;
  localparam int NSRC = 6;
  localparam int SRC_CH1 = 0;
  localparam int SRC_CH2 = 1;
  localparam int SRC_CH3 = 2;
  localparam int SRC_CH4 = 3;
  localparam int SRC_CH5 = 4;
  localparam int SRC_PROT = 5;
endpackage

// File: rtl/trig_src_latch.sv
// trig_src_latch: sticky per-source trigger flags, AND-reduced over the enabled set
module trig_src_latch
  import trig_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm,
  input  logic            armed,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] en,
  output logic            trig_cond
);
  logic [NSRC-1:0] flags_q, flags_d;
  always_comb begin
    flags_d = arm ? '0 : flags_q | (src & en & {NSRC{armed}});
    // an empty enable set must never fire on its own
    trig_cond = (|en) & (&(flags_q | ~en));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
endmodule

// File: rtl/trig_capture.sv
// trig_capture: sequences circular capture RAM writes through pre-trigger, armed and post-trigger phases
module trig_capture
  import trig_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              protTrig,
  input  logic              CH1Trig,
  input  logic              CH2Trig,
  input  logic              CH3Trig,
  input  logic              CH4Trig,
  input  logic              CH5Trig,
  input  logic [NSRC-1:0]   trig_src,
  input  logic              force_trig,
  input  logic              arm,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              smpl_en,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, post_cnt_q, post_cnt_d, trig_addr_q, trig_addr_d, pos_q, pos_d;
  logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d, pre_tgt;
  logic [NSRC-1:0]   src_q, src_d, src_in;
  logic              triggered_q, triggered_d, done_q, done_d, trig_cond, fire;
  always_comb begin
    src_in = '0;
    src_in[SRC_CH1] = CH1Trig;
    src_in[SRC_CH2] = CH2Trig;
    src_in[SRC_CH3] = CH3Trig;
    src_in[SRC_CH4] = CH4Trig;
    src_in[SRC_CH5] = CH5Trig;
    src_in[SRC_PROT] = protTrig;
  end
  trig_src_latch u_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .armed    (state_q == ARMED),
    .src      (src_in),
    .en       (src_q),
    .trig_cond(trig_cond)
  );
  // trig_pos = 0 yields DEPTH pre-samples thanks to the extra counter bit
  assign pre_tgt = {1'b1, {ADDR_W{1'b0}}} - {1'b0, pos_q};
  always_comb begin
    we = smpl_en & ~arm & (state_q inside {PRETRIG, ARMED, POSTTRIG});
    fire = ~arm & (state_q == ARMED) & (trig_cond | force_trig);
  end
  always_comb begin
    state_d = state_q;
    if (arm) state_d = PRETRIG;
    else
      case (state_q)
        PRETRIG:  if (we && pre_cnt_q + 1'b1 == pre_tgt) state_d = ARMED;
        ARMED:    if (fire) state_d = (pos_q == '0) ? DONE : POSTTRIG;
        POSTTRIG: if (we && post_cnt_q + 1'b1 == pos_q) state_d = DONE;
        default:  ;
      endcase
  end
  always_comb begin
    waddr_d = arm ? '0 : waddr_q + ADDR_W'(we);
    pre_cnt_d = arm ? '0 : pre_cnt_q + (ADDR_W + 1)'(we && state_q == PRETRIG);
    post_cnt_d = arm ? '0 : post_cnt_q + ADDR_W'(we && state_q == POSTTRIG);
    triggered_d = ~arm & (triggered_q | fire);
    trig_addr_d = fire ? waddr_d : trig_addr_q;
    done_d = ~arm & (done_q | state_d == DONE);
    src_d = arm ? trig_src : src_q;
    pos_d = arm ? trig_pos : pos_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      src_q       <= '0;
      pos_q       <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      src_q       <= src_d;
      pos_q       <= pos_d;
    end
  assign waddr = waddr_q;
  assign triggered = triggered_q;
  assign trig_addr = trig_addr_q;
  assign capture_done = done_q;
endmodule

// File: tb/tb_trig_capture.sv
// tb_trig_capture: directed capture scenarios with ADDR_W=4 and a sample strobe every 4th cycle
module tb_trig_capture;
  import trig_pkg::*;
  logic clk = 0, rst_n = 0;
  logic protTrig = 0, CH1Trig = 0, CH2Trig = 0, CH3Trig = 0, CH4Trig = 0, CH5Trig = 0;
  logic [5:0] trig_src = '0;
  logic force_trig = 0, arm = 0, smpl_en = 1;
  logic [3:0] trig_pos = '0;
  logic we, triggered, capture_done;
  logic [3:0] waddr, trig_addr;
  int checks = 0, errors = 0, cycle = 0, wcount = 0;
  logic [3:0] wlog [64];

  trig_capture #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .protTrig(protTrig), .CH1Trig(CH1Trig), .CH2Trig(CH2Trig),
    .CH3Trig(CH3Trig), .CH4Trig(CH4Trig), .CH5Trig(CH5Trig), .trig_src(trig_src),
    .force_trig(force_trig), .arm(arm), .trig_pos(trig_pos), .smpl_en(smpl_en),
    .we(we), .waddr(waddr), .triggered(triggered), .trig_addr(trig_addr),
    .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (we) begin
      wlog[wcount[5:0]] = waddr;
      wcount++;
    end
    @(posedge clk);
    #1;
    cycle++;
    smpl_en = (cycle % 4 == 0);
    {protTrig, CH1Trig, CH2Trig, CH3Trig, CH4Trig, CH5Trig, force_trig, arm} = '0;
  endtask

  task automatic do_arm(input logic [5:0] src, input logic [3:0] pos);
    arm = 1;
    trig_src = src;
    trig_pos = pos;
    cyc();
    wcount = 0;
  endtask

  task automatic run_writes(input int n);
    int b = 0;
    while (wcount < n && b < 400) begin
      cyc();
      b++;
    end
    chk("write_budget", wcount, n);
  endtask

  initial begin
    #1;
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trig", triggered, 0);
    chk("rst_taddr", trig_addr, 0);
    chk("rst_done", capture_done, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc();
    chk("idle_no_we", wcount, 0);

    // protocol trigger, 12 pre-samples, 4 post-samples
    do_arm(6'b100000, 4);
    chk("p_arm_state", 32'(dut.state_q), 32'(PRETRIG));
    chk("p_arm_waddr", waddr, 0);
    run_writes(11);
    chk("p_pre11", 32'(dut.state_q), 32'(PRETRIG));
    run_writes(12);
    chk("p_pre12", 32'(dut.state_q), 32'(ARMED));
    run_writes(15);
    chk("p_waddr15", waddr, 15);
    protTrig = 1;
    cyc();
    chk("p_lat1", triggered, 0);
    cyc();
    chk("p_lat2", triggered, 1);
    chk("p_taddr", trig_addr, 15);
    chk("p_post_state", 32'(dut.state_q), 32'(POSTTRIG));
    run_writes(18);
    chk("p_not_done", capture_done, 0);
    run_writes(19);
    chk("p_done", capture_done, 1);
    chk("p_waddr_end", waddr, 3);
    repeat (8) cyc();
    chk("p_no_more", wcount, 19);

    // AND of CH1 and protocol
    do_arm(6'b100001, 2);
    run_writes(14);
    CH1Trig = 1;
    repeat (40) cyc();
    chk("and_ch1_only", triggered, 0);
    protTrig = 1;
    cyc();
    chk("and_lat1", triggered, 0);
    cyc();
    chk("and_trig", triggered, 1);
    chk("and_taddr", trig_addr, 8);
    run_writes(26);
    chk("and_done", capture_done, 1);
    chk("and_waddr", waddr, 10);

    // protocol pulse during PRETRIG is ignored
    do_arm(6'b100000, 3);
    run_writes(5);
    protTrig = 1;
    repeat (3) cyc();
    chk("ign_pre", triggered, 0);
    run_writes(13);
    chk("ign_armed", 32'(dut.state_q), 32'(ARMED));
    repeat (8) cyc();
    chk("ign_no_stale", triggered, 0);
    force_trig = 1;
    cyc();
    chk("ign_force", triggered, 1);
    chk("ign_taddr", trig_addr, 15);
    run_writes(18);
    chk("ign_done", capture_done, 1);
    chk("ign_waddr", waddr, 2);

    // wrap-around, no enabled sources, DONE writes nothing
    do_arm(6'b000000, 1);
    run_writes(20);
    {protTrig, CH1Trig, CH2Trig, CH3Trig, CH4Trig, CH5Trig} = '1;
    repeat (3) cyc();
    chk("wr_src0", triggered, 0);
    run_writes(55);
    force_trig = 1;
    cyc();
    chk("wr_trig", triggered, 1);
    chk("wr_taddr", trig_addr, 7);
    run_writes(56);
    chk("wr_done", capture_done, 1);
    chk("wr_waddr", waddr, 8);
    repeat (12) cyc();
    chk("wr_idle_done", wcount, 56);
    chk("wr_seq14", wlog[14], 14);
    chk("wr_seq15", wlog[15], 15);
    chk("wr_seq16", wlog[16], 0);
    chk("wr_seq17", wlog[17], 1);

    // trig_pos = 0: full-depth pre-trigger, straight to DONE
    do_arm(6'b000000, 0);
    run_writes(15);
    chk("z_pre15", 32'(dut.state_q), 32'(PRETRIG));
    run_writes(16);
    chk("z_armed", 32'(dut.state_q), 32'(ARMED));
    chk("z_waddr", waddr, 0);
    force_trig = 1;
    cyc();
    chk("z_trig", triggered, 1);
    chk("z_done", capture_done, 1);
    chk("z_taddr", trig_addr, 0);
    repeat (12) cyc();
    chk("z_no_writes", wcount, 16);

    // re-arm in POSTTRIG coinciding with a sample, then async reset
    do_arm(6'b100000, 4);
    run_writes(15);
    protTrig = 1;
    cyc();
    cyc();
    chk("rs_trig", triggered, 1);
    run_writes(17);
    repeat (3) cyc();
    arm = 1;
    trig_src = '0;
    trig_pos = 4;
    #1;
    chk("rs_arm_wins", we, 0);
    cyc();
    chk("rs_waddr", waddr, 0);
    chk("rs_trig_clr", triggered, 0);
    chk("rs_state", 32'(dut.state_q), 32'(PRETRIG));
    chk("rs_keep_taddr", trig_addr, 15);
    wcount = 0;
    run_writes(5);
    chk("rs_pre5", waddr, 5);
    rst_n = 0;
    #1;
    chk("rs_waddr0", waddr, 0);
    chk("rs_taddr0", trig_addr, 0);
    chk("rs_trig0", triggered, 0);
    chk("rs_done0", capture_done, 0);
    chk("rs_we0", we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
